vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between two requesters: the display scan-out fetch path, which runs off the VGA timing generator's x/y/active, and the CPU bus. Display reads have fixed priority. CPU writes are posted into a small write FIFO so the CPU rarely stalls. A starvation guard stops continuous display traffic from locking out the CPU. The block sits between the VGA pixel-fetch logic, the CPU bus bridge and the framebuffer BRAM.

Parameters:
ADDR_W, 17, framebuffer word-address width
DATA_W, 32, RAM word width (multiple of 8)
WFIFO_DEPTH, 2, posted-write FIFO entries (power of 2, >=2)
CPU_MAX_WAIT, 4, consecutive CPU-denied cycles before CPU is forced to win one cycle

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
disp_req  in  1  display read request, held until disp_ack
disp_addr  in  ADDR_W  display word address, stable while disp_req=1
disp_ack  out  1  pulse: display read issued to RAM this cycle
disp_rdata  out  DATA_W  display read data
disp_rvalid  out  1  disp_rdata valid, one cycle
disp_late  out  1  sticky: a display request was deferred by the starvation guard
cpu_valid  in  1  CPU request valid
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  write data
cpu_wstrb  in  DATA_W/8  byte enables
cpu_ready  out  1  request accepted this cycle (valid&ready handshake)
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid, one cycle
ram_en  out  1  RAM access this cycle
ram_we  out  DATA_W/8  byte write enables, 0 for reads
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read access

Behaviour:
- Reset (async assert, sync release): FIFO empty, wait counter 0, rsp_owner=NONE, disp_late=0. All outputs are 0 during reset.
- One RAM access per cycle. ram_* are driven combinationally from that cycle's grant. ram_en=0 when nothing is granted.
- Grant priority each cycle:
  (1) If wait_cnt==CPU_MAX_WAIT and the CPU has work, the CPU wins. A concurrent disp_req is deferred and sets disp_late.
  (2) disp_req.
  (3) CPU read: cpu_valid&~cpu_we and the FIFO is empty.
  (4) FIFO head write.
- CPU read vs CPU write when the guard fires: the FIFO head is served first. A read waits for the FIFO to drain, which preserves write→read ordering; there is no forwarding.
- CPU write accept: cpu_ready=~fifo_full, evaluated from registered state. When the FIFO is full, nothing is enqueued even if the head drains in the same cycle.
- CPU read accept: cpu_ready=1 only in the cycle the read is granted to RAM.
- "CPU has work": FIFO non-empty, or a pending read (cpu_valid&~cpu_we).
- wait_cnt: increments, saturating at CPU_MAX_WAIT, in each cycle the CPU has work but is not granted. Clears to 0 on any CPU grant.
- Read return: the registered rsp_owner records the owner of the read granted in cycle N. In cycle N+1, exactly one of disp_rvalid/cpu_rvalid is 1, and the matching rdata equals ram_rdata. The other rvalid is 0.
- Read latency is 1 cycle from grant. Back-to-back reads from alternating owners are fully pipelined.
- disp_ack=1 exactly in the grant cycle.
- disp_late stays at 1 until reset.
- Reset mid-operation: a read in flight is discarded (no rvalid after deassert). FIFO contents are discarded and not written.
- FIFO pointers use an extra wrap bit. Full and empty are derived from the pointers; there is no separate counter.

Decomposition:
- vga_fb_pkg:
  - owner enum {OWN_NONE, OWN_DISP, OWN_CPU}
  - default ADDR_W/DATA_W constants
  - write-entry struct {addr, data, strb}
- Sub-module fb_wfifo: synchronous FIFO with push/pop/full/empty and head output, same clk/reset_n.

Test Plan:
- Reset: hold reset_n=0 with random inputs → all outputs 0. First cycle after release, with disp_req=0 and cpu_valid=0 → ram_en=0.
- Display read: disp_req=1, disp_addr=0x00100 in cycle 3 → cycle 3: ram_en=1, ram_we=0, ram_addr=0x00100, disp_ack=1. Cycle 4: disp_rvalid=1, disp_rdata=RAM word 0x00100.
- Posted writes under display load: disp_req held at 1, three CPU writes → cpu_ready=1,1 then 0. After 4 denied cycles, CPU write 1 wins, disp_late=1, display is acked the next cycle.
- Ordering: write addr 0x10 data 0xDEADBEEF strb 0xF, then read 0x10 → read granted only after the write drains. cpu_rvalid one cycle later with cpu_rdata=0xDEADBEEF.
- Contention: disp_req and a CPU read in the same cycle, FIFO empty → display granted first, CPU read the next cycle. disp_rvalid and cpu_rvalid arrive on consecutive cycles.
- Reset mid-read: grant a CPU read, drop reset_n the next cycle → cpu_rvalid never asserts. FIFO is empty after release.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types for the framebuffer arbiter: read-return owner, grant
// selector and the default posted-write FIFO entry.
package vga_fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 32;

    // Who the read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CPU
    } owner_e;

    // Which requester owns the RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CPU_RD,
        GNT_CPU_WR
    } gnt_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0]   addr;
        logic [FB_DATA_W-1:0]   data;
        logic [FB_DATA_W/8-1:0] strb;
    } wr_entry_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display fetch, CPU bus and framebuffer RAM signals of the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
);
    logic                  disp_req;
    logic [ADDR_W-1:0]     disp_addr;
    logic                  disp_ack;
    logic [DATA_W-1:0]     disp_rdata;
    logic                  disp_rvalid;
    logic                  disp_late;

    logic                  cpu_valid;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W/8-1:0]   cpu_wstrb;
    logic                  cpu_ready;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_rvalid;

    logic                  ram_en;
    logic [DATA_W/8-1:0]   ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  disp_req, disp_addr,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  ram_rdata,
        output disp_ack, disp_rdata, disp_rvalid, disp_late,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output disp_req, disp_addr,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output ram_rdata,
        input  disp_ack, disp_rdata, disp_rvalid, disp_late,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/fb_wfifo.sv
// Posted-write FIFO. Pointers carry an extra wrap bit so full/empty fall
// out of a pointer compare; the head entry is always presented.
module fb_wfifo
    import vga_fb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wr_entry_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    T            mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; a reset throws away whatever was queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads take priority, CPU writes
// are posted through a small FIFO, and a wait counter guarantees the CPU a
// slot after CPU_MAX_WAIT denied cycles.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int WFIFO_DEPTH  = 2,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    vga_fb_arbiter_if.slave bus
);
    localparam int               STRB_W  = DATA_W / 8;
    localparam int               CNT_W   = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wentry_t;

    wentry_t          push_entry, head;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             cpu_rd, cpu_work, guard, cpu_gnt;
    gnt_e             gnt;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    owner_e           rsp_owner_q, rsp_owner_d;
    logic             disp_late_q, disp_late_d;

    assign cpu_rd   = bus.cpu_valid && !bus.cpu_we;
    assign cpu_work = !fifo_empty || cpu_rd;
    assign guard    = (wait_cnt_q == CNT_MAX) && cpu_work;
    assign cpu_gnt  = (gnt == GNT_CPU_RD) || (gnt == GNT_CPU_WR);

    // Writes are accepted purely on registered fullness, so a same-cycle
    // drain never frees a slot early.
    assign fifo_push  = reset_n && bus.cpu_valid && bus.cpu_we && !fifo_full;
    assign fifo_pop   = (gnt == GNT_CPU_WR);
    assign push_entry = '{addr: bus.cpu_addr, data: bus.cpu_wdata, strb: bus.cpu_wstrb};

    fb_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .T     (wentry_t)
    ) u_wfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Grant selection. Under the guard the FIFO drains before any CPU read
    // so a read never overtakes an older posted write.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset_n)                   gnt = GNT_NONE;
        else if (guard)                 gnt = fifo_empty ? GNT_CPU_RD : GNT_CPU_WR;
        else if (bus.disp_req)          gnt = GNT_DISP;
        else if (cpu_rd && fifo_empty)  gnt = GNT_CPU_RD;
        else if (!fifo_empty)           gnt = GNT_CPU_WR;
    end

    // RAM port follows the grant combinationally; idle port drives zeros.
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = '0;
        bus.ram_wdata = '0;
        unique case (gnt)
            GNT_DISP:   bus.ram_addr = bus.disp_addr;
            GNT_CPU_RD: bus.ram_addr = bus.cpu_addr;
            GNT_CPU_WR: begin
                bus.ram_addr  = head.addr;
                bus.ram_we    = head.strb;
                bus.ram_wdata = head.data;
            end
            default: ;
        endcase
    end

    assign bus.ram_en    = (gnt != GNT_NONE);
    assign bus.disp_ack  = (gnt == GNT_DISP);
    assign bus.cpu_ready = reset_n && (bus.cpu_we ? !fifo_full : (gnt == GNT_CPU_RD));

    // Next-state for starvation counter, read-return owner and late flag.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_gnt)
            wait_cnt_d = '0;
        else if (cpu_work && (wait_cnt_q != CNT_MAX))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);

        rsp_owner_d = OWN_NONE;
        if (gnt == GNT_DISP)        rsp_owner_d = OWN_DISP;
        else if (gnt == GNT_CPU_RD) rsp_owner_d = OWN_CPU;

        disp_late_d = disp_late_q || (guard && bus.disp_req);
    end

    // Arbiter state; reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            rsp_owner_q <= OWN_NONE;
            disp_late_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rsp_owner_q <= rsp_owner_d;
            disp_late_q <= disp_late_d;
        end
    end

    // Read data is steered to its owner and zeroed otherwise.
    assign bus.disp_rvalid = (rsp_owner_q == OWN_DISP);
    assign bus.cpu_rvalid  = (rsp_owner_q == OWN_CPU);
    assign bus.disp_rdata  = bus.disp_rvalid ? bus.ram_rdata : '0;
    assign bus.cpu_rdata   = bus.cpu_rvalid  ? bus.ram_rdata : '0;
    assign bus.disp_late   = disp_late_q;

endmodule
